// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that multiplexes byte packets from NUM_REQ requesters onto one
// UART transmit byte stream, with enforced inter-packet gaps and a mid-packet stall timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int GAP_CLKS     = 16,
    parameter int TIMEOUT_CLKS = 1000
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic [NUM_REQ-1:0]     req_val,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_val,
    output logic [7:0]             tx_data,
    input  logic                   tx_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   timeout_err,
    input  logic                   err_clr,
    output logic [1:0]             fsm_state
);

    // Handshake: a byte moves on any rising edge where valid && ready are both high;
    // a source holds valid/data/last stable until it sees ready, and ready never
    // depends on anything but the grant register and tx_ready.

    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = $clog2(TIMEOUT_CLKS) + 1;
    localparam int GW = $clog2(GAP_CLKS) + 1;
    localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT_CLKS - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   owner;
    logic [SW-1:0]   stall_cnt;
    logic [GW-1:0]   gap_cnt;

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic            sending;
    logic            owner_val;
    logic            owner_last;
    logic [7:0]      owner_data;
    logic            xfer;
    logic            pkt_done;
    logic            stall_hit;

    // Search starts one past the last owner so every requester gets a turn.
    always_comb begin
        int            c_int;
        logic [IW-1:0] c;
        win_found = 1'b0;
        win_idx   = ptr;
        c_int     = 0;
        c         = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            c_int = (int'(ptr) + k) % NUM_REQ;
            c     = IW'(c_int);
            if (!win_found && req_val[c]) begin
                win_found = 1'b1;
                win_idx   = c;
            end
        end
    end

    assign sending    = (state == SEND);
    assign owner_val  = req_val[owner];
    assign owner_last = req_last[owner];
    assign owner_data = req_data[{owner, 3'b000} +: 8];

    assign tx_val     = sending && owner_val;
    assign tx_data    = sending ? owner_data : 8'h00;
    assign req_ready  = (sending && tx_ready) ? grant : '0;

    assign xfer       = tx_val && tx_ready;
    assign pkt_done   = xfer && owner_last;
    // Only an absent byte counts as a stall; backpressure from the UART never does.
    assign stall_hit  = sending && !owner_val && (stall_cnt == STALL_LAST);

    assign fsm_state  = state;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state       <= IDLE;
            grant       <= '0;
            owner       <= '0;
            ptr         <= IW'(NUM_REQ - 1);
            stall_cnt   <= '0;
            gap_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (stall_hit) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (win_found) begin
                        state     <= SEND;
                        grant     <= NUM_REQ'(1) << win_idx;
                        owner     <= win_idx;
                        stall_cnt <= '0;
                    end
                end
                SEND: begin
                    if (pkt_done || stall_hit) begin
                        ptr       <= owner;
                        grant     <= '0;
                        stall_cnt <= '0;
                        gap_cnt   <= '0;
                        if (GAP_CLKS > 0) begin
                            state <= GAP;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (owner_val) begin
                        stall_cnt <= '0;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state   <= IDLE;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte sources, a byte/owner scoreboard,
// gap-length tracking and directed timeout / reset scenarios.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int GAP_CLKS     = 2;
    localparam int TIMEOUT_CLKS = 5;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic                 clk;
    logic                 areset;
    logic [NUM_REQ-1:0]   req_val;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_val;
    logic [7:0]           tx_data;
    logic                 tx_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 timeout_err;
    logic                 err_clr;
    logic [1:0]           fsm_state;

    logic [8:0]  src_q[NUM_REQ][$];
    logic [15:0] exp_q[$];
    int          checks;
    int          fails;

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ),
        .GAP_CLKS(GAP_CLKS),
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) dut (
        .clk(clk),
        .areset(areset),
        .req_val(req_val),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .tx_val(tx_val),
        .tx_data(tx_data),
        .tx_ready(tx_ready),
        .grant(grant),
        .timeout_err(timeout_err),
        .err_clr(err_clr),
        .fsm_state(fsm_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Loads n bytes (base + k*step) into requester r; the first n_exp go to the scoreboard.
    task automatic add_pkt(input int r, input int n, input logic [7:0] base, input logic [7:0] step,
                           input bit last_on_final, input int n_exp);
        logic [7:0] d;
        for (int k = 0; k < n; k++) begin
            d = base + 8'(k) * step;
            src_q[r].push_back({(last_on_final && (k == n - 1)), d});
            if (k < n_exp) exp_q.push_back({8'(r), d});
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || fsm_state != ST_IDLE) && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= budget) check_val(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_sent(input string tag, input int budget);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= budget) check_val(tag, 32'd0, 32'd1);
    endtask

    // source driver: advance a requester's queue only after a completed handshake
    initial begin
        logic [NUM_REQ-1:0] acc;
        req_val  = '0;
        req_data = '0;
        req_last = '0;
        forever begin
            @(negedge clk);
            acc = req_val & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    req_val[i]         = 1'b1;
                    req_data[8*i +: 8] = src_q[i][0][7:0];
                    req_last[i]        = src_q[i][0][8];
                end else begin
                    req_val[i]         = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
        end
    end

    // scoreboard monitor
    initial begin
        logic [15:0] e;
        int          gap_run;
        gap_run = 0;
        forever begin
            @(negedge clk);
            if (tx_val && tx_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_xfer", {24'd0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_val("tx_data", {24'd0, tx_data}, {24'd0, e[7:0]});
                    check_val("grant_owner", {28'd0, grant}, 32'(1) << e[15:8]);
                end
            end
            if (fsm_state != ST_SEND)
                check_val("quiet_outputs", {23'd0, grant, tx_val, req_ready}, 32'd0);
            if (areset) begin
                gap_run = 0;
            end else if (fsm_state == ST_GAP) begin
                gap_run++;
            end else if (gap_run != 0) begin
                check_val("gap_len", 32'(gap_run), 32'(GAP_CLKS));
                gap_run = 0;
            end
        end
    end

    initial begin
        int n;
        checks   = 0;
        fails    = 0;
        areset   = 1'b1;
        tx_ready = 1'b0;
        err_clr  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_grant", {28'd0, grant}, 32'd0);
        check_val("rst_tx_val", {31'd0, tx_val}, 32'd0);
        check_val("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        check_val("rst_state", {30'd0, fsm_state}, {30'd0, ST_IDLE});
        areset = 1'b0;
        repeat (2) @(posedge clk);

        // all requesters busy: order 0,1,2,3,0
        tx_ready = 1'b1;
        add_pkt(0, 2, 8'h00, 8'h01, 1'b1, 2);
        add_pkt(1, 2, 8'h10, 8'h01, 1'b1, 2);
        add_pkt(2, 2, 8'h20, 8'h01, 1'b1, 2);
        add_pkt(3, 2, 8'h30, 8'h01, 1'b1, 2);
        add_pkt(0, 2, 8'h40, 8'h01, 1'b1, 2);
        wait_drain("rr_drain", 300);

        // requester 1 packet under toggling backpressure, requester 2 arrives mid-packet
        tx_ready = 1'b0;
        add_pkt(1, 3, 8'h11, 8'h11, 1'b1, 3);
        begin
            int  t;
            bit  pushed2;
            t = 0;
            pushed2 = 1'b0;
            while (!(exp_q.size() == 0 && fsm_state == ST_IDLE) && t < 200) begin
                @(posedge clk);
                #1;
                tx_ready = ~tx_ready;
                if (!pushed2 && exp_q.size() == 2) begin
                    add_pkt(2, 2, 8'hA1, 8'h01, 1'b1, 2);
                    pushed2 = 1'b1;
                end
                t++;
            end
            if (t >= 200) check_val("toggle_drain", 32'd0, 32'd1);
            check_val("req2_joined", {31'd0, pushed2}, 32'd1);
        end
        tx_ready = 1'b1;

        // requester 3 sends one byte then stalls: timeout after TIMEOUT_CLKS cycles
        add_pkt(3, 1, 8'h3C, 8'h01, 1'b0, 1);
        wait_sent("to_first_byte", 50);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            #1;
            if (timeout_err) break;
            n++;
        end
        check_val("stall_cycles", 32'(n), 32'(TIMEOUT_CLKS));
        check_val("to_grant", {28'd0, grant}, 32'd0);
        check_val("to_state", {30'd0, fsm_state}, {30'd0, ST_GAP});
        wait_drain("to_gap_drain", 50);
        add_pkt(0, 1, 8'h50, 8'h01, 1'b1, 1);
        add_pkt(1, 1, 8'h60, 8'h01, 1'b1, 1);
        wait_drain("after_to_drain", 100);
        check_val("err_sticky", {31'd0, timeout_err}, 32'd1);
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check_val("err_cleared", {31'd0, timeout_err}, 32'd0);

        // timeout again with err_clr in the same cycle: set wins
        add_pkt(3, 1, 8'h3D, 8'h01, 1'b0, 1);
        wait_sent("to2_first_byte", 50);
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check_val("err_not_early", {31'd0, timeout_err}, 32'd0);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check_val("err_set_wins", {31'd0, timeout_err}, 32'd1);
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check_val("err_clr_alone", {31'd0, timeout_err}, 32'd0);
        wait_drain("to2_drain", 50);

        // long UART backpressure with data present never times out
        tx_ready = 1'b0;
        add_pkt(0, 1, 8'h5A, 8'h01, 1'b1, 1);
        repeat (2000) @(posedge clk);
        #1;
        check_val("bp_no_timeout", {31'd0, timeout_err}, 32'd0);
        check_val("bp_held", 32'(exp_q.size()), 32'd1);
        check_val("bp_grant", {28'd0, grant}, 32'b0001);
        tx_ready = 1'b1;
        wait_drain("bp_drain", 50);
        check_val("bp_no_timeout_end", {31'd0, timeout_err}, 32'd0);

        // reset during byte 2 of a 4-byte packet
        add_pkt(1, 4, 8'h71, 8'h01, 1'b1, 1);
        wait_sent("rst_first_byte", 50);
        @(posedge clk);
        #1;
        check_val("byte2_presented", {31'd0, tx_val}, 32'd1);
        check_val("byte2_data", {24'd0, tx_data}, 32'h72);
        #1;
        areset = 1'b1;
        #1;
        check_val("arst_tx_val", {31'd0, tx_val}, 32'd0);
        check_val("arst_grant", {28'd0, grant}, 32'd0);
        check_val("arst_ready", {28'd0, req_ready}, 32'd0);
        for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
        repeat (3) @(posedge clk);
        #1;
        add_pkt(0, 1, 8'h80, 8'h01, 1'b1, 1);
        add_pkt(1, 1, 8'h90, 8'h01, 1'b1, 1);
        areset = 1'b0;
        wait_drain("post_rst_drain", 100);
        check_val("post_rst_err", {31'd0, timeout_err}, 32'd0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter GAP_CLKS, default 16, idle clocks forced between packets (0 allowed).
REQ-003 SHALL have parameter TIMEOUT_CLKS, default 1000, mid-packet stall limit in clocks (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port areset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_val  input  NUM_REQ  per-requester byte valid.
REQ-007 SHALL have port req_data  input  8*NUM_REQ  requester i byte at bits [8i+7:8i].
REQ-008 SHALL have port req_last  input  NUM_REQ  marks final byte of requester's packet.
REQ-009 SHALL have port req_ready  output  NUM_REQ  per-requester byte accept.
REQ-010 SHALL have port tx_val  output  1  byte valid toward UART transmitter.
REQ-011 SHALL have port tx_data  output  8  byte toward UART transmitter.
REQ-012 SHALL have port tx_ready  input  1  UART transmitter accepts byte.
REQ-013 SHALL have port grant  output  NUM_REQ  one-hot current owner, all-zero when none.
REQ-014 SHALL have port timeout_err  output  1  sticky stall flag.
REQ-015 SHALL have port err_clr  input  1  clears timeout_err.

Function
REQ-016 SHALL implement states IDLE, SEND, GAP.
REQ-017 IDLE: grant=0, tx_val=0, req_ready=0; any req_val high in cycle n -> SEND with grant set in cycle n+1.
REQ-018 Arbitration SHALL be round-robin: search starts at index (ptr+1) mod NUM_REQ, first req_val high wins.
REQ-019 ptr SHALL update to winner index when its packet ends (last transfer or timeout).
REQ-020 SEND: tx_val=req_val[g], tx_data=req_data[g], req_ready[g]=tx_ready, all other req_ready=0 (combinational pass-through, zero added latency).
REQ-021 Transfer SHALL occur in a cycle with tx_val && tx_ready; grant SHALL be held across bytes until the transfer with req_last[g]=1.
REQ-022 Non-granted req_val/req_data/req_last SHALL have no effect on tx_* in SEND.
REQ-023 On last transfer: GAP_CLKS>0 -> GAP; GAP_CLKS=0 -> IDLE next cycle.
REQ-024 GAP: grant=0, tx_val=0, req_ready=0 for exactly GAP_CLKS cycles, then IDLE.
REQ-025 Stall counter in SEND SHALL increment each cycle req_val[g]=0, reset to 0 on any cycle req_val[g]=1, and reset on entering SEND.
REQ-026 Stall counter reaching TIMEOUT_CLKS SHALL set timeout_err, end the packet (ptr=g), and go to GAP/IDLE per REQ-023 rules.
REQ-027 Stalls caused by tx_ready=0 with req_val[g]=1 SHALL never time out.
REQ-028 err_clr SHALL clear timeout_err next cycle; simultaneous set and err_clr -> timeout_err=1.
REQ-029 Single-byte packet (req_last on first byte) SHALL be legal.
REQ-030 Counters SHALL be sized to $clog2 of their limits +1; no wrap reachable.
REQ-031 Requester obligation: once req_val[i] high, hold req_val/req_data/req_last stable until req_ready[i]; arbiter need not check.

Reset
REQ-032 areset SHALL immediately force state=IDLE, grant=0, tx_val=0, req_ready=0, timeout_err=0, counters=0, ptr=NUM_REQ-1 (requester 0 wins first).
REQ-033 areset mid-packet SHALL abandon the packet with no further byte forwarded; first post-reset grant follows REQ-018 from ptr=NUM_REQ-1.

Verification
REQ-034 All req_val high from reset, each 2-byte packet, tx_ready=1, GAP_CLKS=2 -> grant order 0,1,2,3,0; 2 idle cycles between packets.
REQ-035 Req 1 sends 0x11,0x22,0x33(last) with tx_ready toggling; req 2 asserts mid-packet -> tx_data sequence 0x11,0x22,0x33 uninterrupted, grant=0b0100 only after GAP.
REQ-036 Req 3 sends one byte then drops req_val, TIMEOUT_CLKS=5 -> timeout_err=1 after 5 stall cycles, grant=0, next winner req 0.
REQ-037 Same as REQ-036 with err_clr pulsed on the timeout cycle -> timeout_err stays 1; later err_clr alone -> 0.
REQ-038 tx_ready held 0 for 2000 cycles with req_val[g]=1 -> no timeout, byte delivered when tx_ready rises.
REQ-039 areset asserted during byte 2 of a 4-byte packet -> tx_val/grant 0 same cycle; after release, requester 0 granted first if requesting.
